// File: rtl/pkt_sched.sv
// -----------------------------------------------------------------------------
// pkt_sched -- capture scheduler between the descriptor source and wr_ctrl.
//
// Accepts one packet descriptor at a time. At accept it applies these checks:
//   - capture enable
//   - packet limit (cap_done)
//   - empty or negative span
//   - snap-length truncation
// It latches the descriptor and the live timestamp, fires a one-cycle start
// pulse to wr_ctrl and holds the latched values until wr_ctrl_rdy. A watchdog
// guards each transfer. A fixed idle gap follows every completion so that
// wr_ctrl can return from DONE to IDLE.
//
// Parameters
//   GAP_CYCLES  idle cycles after each completion (>= 2)
//   TO_W        width of the watchdog counter and cfg_timeout
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   desc_valid/desc_ready      descriptor handshake
//   desc_begin/desc_end        packet span (end exclusive)
//   seconds/nanoseconds        live timestamp
//   cfg_*                      enable, packet limit, snap length,
//                              watchdog limit, clear pulse
//   wr_ctrl, wr_ctrl_rdy       start pulse / completion pulse
//   pkt_begin/pkt_end, ts_*    values held for wr_ctrl
//   busy, pkt_done             status
//   cap_done, err_timeout      sticky flags
//   pkt_count, drop_count      statistics
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module pkt_sched #(
  parameter int GAP_CYCLES = 2,
  parameter int TO_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            desc_valid,
  output logic            desc_ready,
  input  logic [31:0]     desc_begin,
  input  logic [31:0]     desc_end,
  input  logic [31:0]     seconds,
  input  logic [31:0]     nanoseconds,
  input  logic            cfg_enable,
  input  logic [31:0]     cfg_max_pkts,
  input  logic [31:0]     cfg_snaplen,
  input  logic [TO_W-1:0] cfg_timeout,
  input  logic            cfg_clear,
  output logic            wr_ctrl,
  output logic [31:0]     pkt_begin,
  output logic [31:0]     pkt_end,
  output logic [31:0]     ts_seconds,
  output logic [31:0]     ts_nanoseconds,
  input  logic            wr_ctrl_rdy,
  output logic            busy,
  output logic            pkt_done,
  output logic            cap_done,
  output logic            err_timeout,
  output logic [31:0]     pkt_count,
  output logic [31:0]     drop_count
);

  localparam int              GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  WD_ONE   = TO_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic              desc_ready_r;
  logic              wr_ctrl_r;
  logic              busy_r;
  logic              pkt_done_r;
  logic              cap_done_r;
  logic              err_timeout_r;
  logic [31:0]       pkt_count_r;
  logic [31:0]       drop_count_r;
  logic [31:0]       pkt_begin_r;
  logic [31:0]       pkt_end_r;
  logic [31:0]       ts_seconds_r;
  logic [31:0]       ts_nanoseconds_r;
  logic [TO_W-1:0]   wd_r;
  logic [GAP_W-1:0]  gap_cnt_r;

  logic              desc_ready_s;
  logic              wr_ctrl_s;
  logic              busy_s;

  logic              accept_s;
  logic              drop_s;
  logic              take_s;
  logic              done_s;
  logic              timeout_s;
  logic              gap_last_s;
  logic [31:0]       len_s;
  logic [31:0]       snap_end_s;
  logic [31:0]       pkt_inc_s;
  logic              limit_hit_s;

  assign desc_ready     = desc_ready_r;
  assign wr_ctrl        = wr_ctrl_r;
  assign busy           = busy_r;
  assign pkt_done       = pkt_done_r;
  assign cap_done       = cap_done_r;
  assign err_timeout    = err_timeout_r;
  assign pkt_count      = pkt_count_r;
  assign drop_count     = drop_count_r;
  assign pkt_begin      = pkt_begin_r;
  assign pkt_end        = pkt_end_r;
  assign ts_seconds     = ts_seconds_r;
  assign ts_nanoseconds = ts_nanoseconds_r;

  // Handshake and event decode shared by the FSM and the statistics.
  // desc_ready_r is only high in IDLE, and never in the reset cycle,
  // so it doubles as the IDLE qualifier for an accept.
  always_comb begin
    accept_s    = desc_valid & desc_ready_r;
    drop_s      = accept_s & (~cfg_enable | cap_done_r | (desc_end <= desc_begin));
    take_s      = accept_s & ~drop_s;
    done_s      = (state_r == ST_BUSY) & wr_ctrl_rdy;
    // A completion in the same cycle takes priority over the watchdog.
    timeout_s   = (state_r == ST_BUSY) & ~wr_ctrl_rdy &
                  (cfg_timeout != '0) & (wd_r == cfg_timeout);
    gap_last_s  = (gap_cnt_r == GAP_LAST);
    pkt_inc_s   = pkt_count_r + 32'd1;
    limit_hit_s = (cfg_max_pkts != 32'd0) & (pkt_inc_s == cfg_max_pkts);
  end

  // Snap-length truncation of the accepted span.
  always_comb begin
    len_s = desc_end - desc_begin;
    if ((cfg_snaplen == 32'd0) || (len_s <= cfg_snaplen)) begin
      snap_end_s = desc_end;
    end else begin
      snap_end_s = desc_begin + cfg_snaplen;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_BUSY;
      end
      ST_BUSY: begin
        if (done_s) begin
          state_nxt_s = ST_GAP;
        end else if (timeout_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_GAP: begin
        if (gap_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_ERR: begin
        if (cfg_clear) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    desc_ready_s = 1'b0;
    wr_ctrl_s    = 1'b0;
    busy_s       = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        desc_ready_s = 1'b1;
      end
      ST_START: begin
        wr_ctrl_s = 1'b1;
        busy_s    = 1'b1;
      end
      ST_BUSY: begin
        busy_s = 1'b1;
      end
      ST_GAP: begin
        desc_ready_s = 1'b0;
      end
      ST_ERR: begin
        desc_ready_s = 1'b0;
      end
      default: begin
        desc_ready_s = 1'b0;
      end
    endcase
  end

  // Output registers for the FSM-derived strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      desc_ready_r <= 1'b0;
      wr_ctrl_r    <= 1'b0;
      busy_r       <= 1'b0;
      pkt_done_r   <= 1'b0;
    end else begin
      desc_ready_r <= desc_ready_s;
      wr_ctrl_r    <= wr_ctrl_s;
      busy_r       <= busy_s;
      pkt_done_r   <= done_s;
    end
  end

  // Descriptor and timestamp latch; only a non-dropped accept updates them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_begin_r      <= 32'd0;
      pkt_end_r        <= 32'd0;
      ts_seconds_r     <= 32'd0;
      ts_nanoseconds_r <= 32'd0;
    end else if (take_s) begin
      pkt_begin_r      <= desc_begin;
      pkt_end_r        <= snap_end_s;
      ts_seconds_r     <= seconds;
      ts_nanoseconds_r <= nanoseconds;
    end else begin
      pkt_begin_r      <= pkt_begin_r;
      pkt_end_r        <= pkt_end_r;
      ts_seconds_r     <= ts_seconds_r;
      ts_nanoseconds_r <= ts_nanoseconds_r;
    end
  end

  // Watchdog: zero outside BUSY, so it reads 0 on the first BUSY cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_r <= '0;
    end else if (state_r == ST_BUSY) begin
      wd_r <= wd_r + WD_ONE;
    end else begin
      wd_r <= '0;
    end
  end

  // Gap counter: counts the GAP cycles already spent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_cnt_r <= '0;
    end else if (state_r == ST_GAP) begin
      gap_cnt_r <= gap_cnt_r + GAP_ONE;
    end else begin
      gap_cnt_r <= '0;
    end
  end

  // Statistics and sticky flags. A clear in the same cycle as an event
  // wins, so that event is not counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_count_r   <= 32'd0;
      drop_count_r  <= 32'd0;
      cap_done_r    <= 1'b0;
      err_timeout_r <= 1'b0;
    end else if (cfg_clear) begin
      pkt_count_r   <= 32'd0;
      drop_count_r  <= 32'd0;
      cap_done_r    <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      if (done_s) begin
        pkt_count_r <= pkt_inc_s;
      end else begin
        pkt_count_r <= pkt_count_r;
      end
      if (drop_s) begin
        drop_count_r <= drop_count_r + 32'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
      if (done_s && limit_hit_s) begin
        cap_done_r <= 1'b1;
      end else begin
        cap_done_r <= cap_done_r;
      end
      if (timeout_s) begin
        err_timeout_r <= 1'b1;
      end else begin
        err_timeout_r <= err_timeout_r;
      end
    end
  end

endmodule

// File: doc/pkt_sched.md
# pkt_sched

Capture scheduler that sits between the packet-descriptor source and `wr_ctrl`. It accepts one descriptor at a time, applies enable, packet-limit and snap-length policy, and latches the descriptor and its timestamp. It then pulses `wr_ctrl` and holds its inputs stable until `wr_ctrl_rdy`. It also keeps capture statistics and flags, and runs a watchdog on each transfer.

## Interface
- `GAP_CYCLES`, default 2: idle cycles after each `wr_ctrl_rdy` before the next descriptor is accepted. Must be ≥2, so `wr_ctrl` can pass DONE→IDLE.
- `TO_W`, default 16: width of the watchdog counter and of `cfg_timeout`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `desc_valid` in 1: descriptor valid.
- `desc_ready` out 1: descriptor accept.
- `desc_begin` in 32: packet start address.
- `desc_end` in 32: packet end address (exclusive).
- `seconds` in 32: live timestamp, seconds.
- `nanoseconds` in 32: live timestamp, nanoseconds.
- `cfg_enable` in 1: capture enable.
- `cfg_max_pkts` in 32: packet limit; 0 = unlimited.
- `cfg_snaplen` in 32: maximum bytes per packet; 0 = no truncation.
- `cfg_timeout` in TO_W: watchdog limit in cycles; 0 = disabled.
- `cfg_clear` in 1: one-cycle pulse; clears counters and sticky flags.
- `wr_ctrl` out 1: one-cycle start pulse to `wr_ctrl`.
- `pkt_begin` out 32: held to `wr_ctrl`.
- `pkt_end` out 32: held to `wr_ctrl`.
- `ts_seconds` out 32: timestamp latched at accept.
- `ts_nanoseconds` out 32: timestamp latched at accept.
- `wr_ctrl_rdy` in 1: completion pulse from `wr_ctrl`.
- `busy` out 1: high in START and BUSY.
- `pkt_done` out 1: one-cycle pulse per completed packet.
- `cap_done` out 1: sticky; packet limit reached.
- `err_timeout` out 1: sticky; watchdog fired.
- `pkt_count` out 32: completed packets.
- `drop_count` out 32: dropped descriptors.

## Operation
- States: IDLE, START, BUSY, GAP, ERR.
- IDLE:
  - `desc_ready`=1.
  - On `desc_valid`, the descriptor is consumed.
  - The descriptor is dropped (`drop_count`+1, stay in IDLE) if any of the following holds: `cfg_enable`=0, `cap_done`=1, or `desc_end` ≤ `desc_begin` (unsigned compare).
  - Otherwise:
    - `pkt_begin` ← `desc_begin`.
    - len = `desc_end` − `desc_begin`, mod 2^32.
    - `pkt_end` ← `desc_begin` + len if `cfg_snaplen`=0 or len ≤ `cfg_snaplen`; otherwise `desc_begin` + `cfg_snaplen`.
    - `ts_seconds`/`ts_nanoseconds` ← `seconds`/`nanoseconds`.
    - Go to START.
- START: `wr_ctrl`=1 for exactly one cycle, then BUSY.
- BUSY:
  - The watchdog counts up each cycle; it is cleared on entry.
  - On `wr_ctrl_rdy`:
    - `pkt_count`+1 and `pkt_done` pulse.
    - If `cfg_max_pkts`≠0 and the new count equals `cfg_max_pkts`, set `cap_done`.
    - Go to GAP.
  - Else, if `cfg_timeout`≠0 and watchdog == `cfg_timeout`: set `err_timeout`, go to ERR.
  - `wr_ctrl_rdy` wins over a timeout in the same cycle.
- GAP: `desc_ready`=0 for `GAP_CYCLES` cycles, then IDLE.
- ERR:
  - `desc_ready`=0 (backpressure, no drops).
  - Held until `cfg_clear`, then IDLE.
- `wr_ctrl_rdy` outside BUSY is ignored.
- Held outputs: `pkt_begin`, `pkt_end` and `ts_*` change only on an accepted, non-dropped descriptor.
- `cfg_clear`:
  - Zeroes `pkt_count`, `drop_count`, `cap_done` and `err_timeout`.
  - Does not abort START, BUSY or GAP.
  - If it coincides with a completion or drop, clear wins and the event is not counted; `pkt_done` still pulses.
- Counters wrap at 2^32.
- Config inputs are sampled live; they are used only at accept and in BUSY.

## Timing
- Reset values:
  - State IDLE.
  - `desc_ready`=0 in the reset cycle, 1 afterwards.
  - All other outputs 0.
- Reset mid-transfer returns to IDLE immediately. No `wr_ctrl_rdy` is awaited and none is counted.
- Accept at cycle N (`desc_valid`&`desc_ready`):
  - `pkt_begin`/`pkt_end`/`ts_*` valid from N+1.
  - `wr_ctrl`=1 at N+1 only.
  - `busy`=1 from N+1 until the `wr_ctrl_rdy` cycle, inclusive.
- `wr_ctrl_rdy` at cycle M:
  - `pkt_done`=1 and `pkt_count` updated at M+1.
  - `desc_ready`=0 for M+1 … M+GAP_CYCLES; `desc_ready`=1 at M+GAP_CYCLES+1.
- Drop at N: `drop_count` updated at N+1; `desc_ready` stays 1 (one descriptor per cycle).
- Watchdog: with `cfg_timeout`=T, `err_timeout`=1 T+1 cycles after the first BUSY cycle, if no `wr_ctrl_rdy`.

## Test plan
- Single descriptor, begin=0x1000, end=0x1040, snaplen=0; `wr_ctrl_rdy` 20 cycles after START → `wr_ctrl` pulses once, `pkt_end`=0x1040, `pkt_count`=1, `desc_ready` returns 3 cycles after rdy.
- snaplen=0x20, begin=0x2000, end=0x2100 → `pkt_end`=0x2020; snaplen=0x200 on the same descriptor → 0x2100.
- `cfg_max_pkts`=2, four back-to-back descriptors with immediate rdy → `pkt_count`=2, `cap_done`=1, `drop_count`=2, only two `wr_ctrl` pulses.
- `cfg_enable`=0, or end=begin=0x3000 → descriptor consumed, `drop_count`+1, no `wr_ctrl`.
- `cfg_timeout`=10, rdy withheld → `err_timeout`=1 at BUSY+11, `desc_ready`=0; `cfg_clear` → IDLE, flag and counters 0. Repeat with rdy on the timeout cycle → no error, `pkt_count`=1.
- Reset asserted in BUSY, then a late rdy → all outputs 0, rdy ignored, `pkt_count`=0.
